// File: rtl/mod12_counter_if.sv
// Bundles the count-enable input with the count and carry outputs of the
// modulo counter so a stage can be wired up (or cascaded) as one port.
interface mod12_counter_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic [WIDTH-1:0] Q;
    logic             CO;

    // The driver of the enable, e.g. a previous prescaler stage or a bench
    modport master (
        output EN,
        input  Q,
        input  CO
    );

    // The counter itself
    modport slave (
        input  EN,
        output Q,
        output CO
    );
endinterface

// File: rtl/mod12_counter.sv
// Synchronous modulo-MODULUS up-counter with count enable and a terminal-count
// carry. Q walks 0..MODULUS-1 on enabled edges. CO flags the enabled cycle in
// which Q sits at terminal count, so it can drive the enable of a next stage.
// MODULUS must lie in 2..2**WIDTH.
module mod12_counter #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic              CLK,
    input  logic              MR,
    mod12_counter_if.slave    bus
);

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count;

    // Count register: reset has priority over enable. The ">=" compare also
    // pulls an out-of-range power-up value back to zero on the first enabled
    // edge, and it keeps the increment from ever overflowing WIDTH bits.
    always_ff @(posedge CLK) begin
        if (MR) begin
            count <= '0;
        end else if (bus.EN) begin
            if (count >= TERMINAL) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

    // Carry is combinational from the count and enable, and ignores reset, so
    // a cascaded stage sees it in the same cycle the wrap is about to happen
    always_comb begin
        bus.CO = bus.EN && (count == TERMINAL);
    end

    assign bus.Q = count;

endmodule

// File: tb/tb_mod12_counter.sv
// Self-checking bench for mod12_counter. A behavioural model predicts the next
// count when each cycle's inputs are driven; the prediction is queued and
// popped once the clock edge has produced the DUT's new Q. CO is checked
// combinationally before the edge.
module tb_mod12_counter;

    localparam int MODULUS = 12;
    localparam int WIDTH   = 4;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic CLK = 1'b0;
    logic MR;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] model_q;
    logic [WIDTH-1:0] exp_q_queue[$];

    mod12_counter_if #(.WIDTH(WIDTH)) bus ();

    mod12_counter #(
        .MODULUS(MODULUS),
        .WIDTH  (WIDTH)
    ) dut (
        .CLK(CLK),
        .MR (MR),
        .bus(bus)
    );

    // 10 time-unit clock
    always #5 CLK = ~CLK;

    // Drives one cycle of inputs at the falling edge, samples CO before the
    // rising edge, queues the predicted Q, then pops it after the edge
    task automatic drive_cycle(input logic mr, input logic en,
                               output logic obs_co, output logic exp_co,
                               output logic [WIDTH-1:0] obs_q,
                               output logic [WIDTH-1:0] exp_q);
        logic [WIDTH-1:0] next_q;
        @(negedge CLK);
        MR     = mr;
        bus.EN = en;
        #1;
        obs_co = bus.CO;
        exp_co = en && (model_q == LAST);
        if (mr)
            next_q = '0;
        else if (en)
            next_q = (model_q == LAST) ? '0 : model_q + WIDTH'(1);
        else
            next_q = model_q;
        exp_q_queue.push_back(next_q);
        model_q = next_q;
        @(posedge CLK);
        #1;
        obs_q = bus.Q;
        if (exp_q_queue.size() > 0)
            exp_q = exp_q_queue.pop_front();
        else
            exp_q = 'x;
    endtask

    task automatic test_reset();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, oc, ec, oq, eq);
            vectors++;
            if (oc !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_co cycle %0d: got %b expected 0", i, oc);
            end
            vectors++;
            if (oq !== 4'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_q cycle %0d: got %0d expected 0", i, oq);
            end
        end
        drive_cycle(1'b1, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_priority_q: got %0d expected 0", oq);
        end
    endtask

    task automatic test_full_count();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
            vectors++;
            if (oc !== ec) begin
                miscompares++;
                $display("[TB] FAIL count_co step %0d: got %b expected %b", i, oc, ec);
            end
            vectors++;
            if (oq !== eq) begin
                miscompares++;
                $display("[TB] FAIL count_q step %0d: got %0d expected %0d", i, oq, eq);
            end
        end
    endtask

    task automatic test_hold();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        drive_cycle(1'b1, 1'b0, oc, ec, oq, eq);
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd5) begin
            miscompares++;
            $display("[TB] FAIL hold_reach5: got %0d expected 5", oq);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, oc, ec, oq, eq);
            vectors++;
            if (oc !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold_co cycle %0d: got %b expected 0", i, oc);
            end
            vectors++;
            if (oq !== 4'd5) begin
                miscompares++;
                $display("[TB] FAIL hold_q cycle %0d: got %0d expected 5", i, oq);
            end
        end
        drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd6) begin
            miscompares++;
            $display("[TB] FAIL hold_resume_q: got %0d expected 6", oq);
        end
    endtask

    task automatic test_terminal_enable_low();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd11) begin
            miscompares++;
            $display("[TB] FAIL term_reach11: got %0d expected 11", oq);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, oc, ec, oq, eq);
            vectors++;
            if (oc !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL term_co_en_low cycle %0d: got %b expected 0", i, oc);
            end
            vectors++;
            if (oq !== 4'd11) begin
                miscompares++;
                $display("[TB] FAIL term_hold_q cycle %0d: got %0d expected 11", i, oq);
            end
        end
        drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL term_co_en_high: got %b expected 1", oc);
        end
        vectors++;
        if (oq !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL term_wrap_q: got %0d expected 0", oq);
        end
    endtask

    task automatic test_reset_at_terminal();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        for (int i = 0; i < 11; i++)
            drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        drive_cycle(1'b1, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mr_term_co: got %b expected 1", oc);
        end
        vectors++;
        if (oq !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL mr_term_q: got %0d expected 0", oq);
        end
    endtask

    task automatic test_mid_reset();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        for (int i = 0; i < 7; i++)
            drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd7) begin
            miscompares++;
            $display("[TB] FAIL mid_reach7: got %0d expected 7", oq);
        end
        drive_cycle(1'b1, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_q: got %0d expected 0", oq);
        end
        drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL mid_after_q: got %0d expected 1", oq);
        end
    endtask

    task automatic test_edge_only_reset();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        // now 1 time unit past a rising edge with EN still high
        #1 MR = 1'b1;
        #2 MR = 1'b0;
        vectors++;
        if (bus.Q !== model_q) begin
            miscompares++;
            $display("[TB] FAIL glitch_now_q: got %0d expected %0d", bus.Q, model_q);
        end
        drive_cycle(1'b0, 1'b1, oc, ec, oq, eq);
        vectors++;
        if (oq !== eq) begin
            miscompares++;
            $display("[TB] FAIL glitch_next_q: got %0d expected %0d", oq, eq);
        end
    endtask

    task automatic test_back_to_back();
        logic oc, ec;
        logic [WIDTH-1:0] oq, eq;
        logic mr, en;
        for (int i = 0; i < 40; i++) begin
            mr = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            drive_cycle(mr, en, oc, ec, oq, eq);
            vectors++;
            if (oc !== ec) begin
                miscompares++;
                $display("[TB] FAIL rand_co step %0d: got %b expected %b", i, oc, ec);
            end
            vectors++;
            if (oq !== eq) begin
                miscompares++;
                $display("[TB] FAIL rand_q step %0d: got %0d expected %0d", i, oq, eq);
            end
        end
    endtask

    initial begin
        MR      = 1'b1;
        bus.EN  = 1'b0;
        model_q = 'x;
        test_reset();
        test_full_count();
        test_hold();
        test_terminal_enable_low();
        test_reset_at_terminal();
        test_mid_reset();
        test_edge_only_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
